// File: rtl/rv32im_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rv32im_mem_arbiter
//  Description : Single-outstanding arbiter sharing the core memory port
//                between IFU and LSU, with an IFU starvation guard and a
//                wait-state timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module rv32im_mem_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              ifu_req_i,
   input  logic [ADDR_W-1:0] ifu_addr_i,
   output logic              ifu_ack_o,
   output logic [DATA_W-1:0] ifu_rdata_o,
   output logic              ifu_err_o,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [3:0]        lsu_be_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [DATA_W-1:0] lsu_wdata_i,
   output logic              lsu_ack_o,
   output logic [DATA_W-1:0] lsu_rdata_o,
   output logic              lsu_err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [3:0]  c_STARVE_MAX = 4'(STARVE_MAX);
   localparam logic [15:0] c_TMO_LAST   = 16'(TIMEOUT - 1);

   state_t      r_state;
   logic [3:0]  r_starve_cnt;
   logic [15:0] r_tmo_cnt;
   logic        r_owner_ifu;

   logic w_grant_ifu;
   logic w_grant_lsu;

   // LSU normally wins; IFU only jumps the queue once it has been passed over STARVE_MAX times.
   assign w_grant_ifu = ifu_req_i & (~lsu_req_i | (r_starve_cnt == c_STARVE_MAX));
   assign w_grant_lsu = lsu_req_i & ~w_grant_ifu;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state      <= S_IDLE;
         r_starve_cnt <= '0;
         r_tmo_cnt    <= '0;
         r_owner_ifu  <= 1'b0;
         ifu_ack_o    <= 1'b0;
         ifu_rdata_o  <= '0;
         ifu_err_o    <= 1'b0;
         lsu_ack_o    <= 1'b0;
         lsu_rdata_o  <= '0;
         lsu_err_o    <= 1'b0;
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_be_o     <= '0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
      end else begin
         ifu_ack_o   <= 1'b0;
         ifu_rdata_o <= '0;
         ifu_err_o   <= 1'b0;
         lsu_ack_o   <= 1'b0;
         lsu_rdata_o <= '0;
         lsu_err_o   <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_grant_ifu) begin
                  mem_req_o    <= 1'b1;
                  mem_we_o     <= 1'b0;
                  mem_be_o     <= 4'hF;
                  mem_addr_o   <= ifu_addr_i;
                  mem_wdata_o  <= '0;
                  r_owner_ifu  <= 1'b1;
                  r_starve_cnt <= '0;
                  r_tmo_cnt    <= '0;
                  r_state      <= S_BUSY;
               end else if (w_grant_lsu) begin
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= lsu_we_i;
                  mem_be_o    <= lsu_be_i;
                  mem_addr_o  <= lsu_addr_i;
                  mem_wdata_o <= lsu_wdata_i;
                  r_owner_ifu <= 1'b0;
                  r_tmo_cnt   <= '0;
                  r_state     <= S_BUSY;
                  if (ifu_req_i && (r_starve_cnt != c_STARVE_MAX))
                     r_starve_cnt <= r_starve_cnt + 4'd1;
               end
            end

            S_BUSY: begin
               r_tmo_cnt <= r_tmo_cnt + 16'd1;
               // A bus ack in the final wait cycle still counts as success.
               if (mem_ack_i || (r_tmo_cnt == c_TMO_LAST)) begin
                  mem_req_o <= 1'b0;
                  r_state   <= S_RESP;
                  if (r_owner_ifu) begin
                     ifu_ack_o   <= 1'b1;
                     ifu_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                     ifu_err_o   <= ~mem_ack_i;
                  end else begin
                     lsu_ack_o   <= 1'b1;
                     lsu_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                     lsu_err_o   <= ~mem_ack_i;
                  end
               end
            end

            S_RESP: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rv32im_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32im_mem_arbiter
//  Description : Directed and randomized transaction checks for the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv32im_mem_arbiter;

   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 8;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        ifu_req_i = 1'b0;
   logic [31:0] ifu_addr_i = '0;
   logic        ifu_ack_o;
   logic [31:0] ifu_rdata_o;
   logic        ifu_err_o;
   logic        lsu_req_i = 1'b0;
   logic        lsu_we_i = 1'b0;
   logic [3:0]  lsu_be_i = '0;
   logic [31:0] lsu_addr_i = '0;
   logic [31:0] lsu_wdata_i = '0;
   logic        lsu_ack_o;
   logic [31:0] lsu_rdata_o;
   logic        lsu_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   int n_vec = 0;
   int n_err = 0;
   int m_starve = 0;
   int obs_win = 0;
   logic [5:0] seq;

   rv32im_mem_arbiter #(
      .DATA_W(32), .ADDR_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_ack_o(ifu_ack_o),
      .ifu_rdata_o(ifu_rdata_o), .ifu_err_o(ifu_err_o),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
      .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_ack_o(lsu_ack_o),
      .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem"}, {27'd0, mem_req_o, mem_we_o, mem_be_o}, 32'd0);
      chk({tag, "_addr"}, mem_addr_o, 32'd0);
      chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
      chk({tag, "_ifu"}, {30'd0, ifu_ack_o, ifu_err_o}, 32'd0);
      chk({tag, "_lsu"}, {30'd0, lsu_ack_o, lsu_err_o}, 32'd0);
      chk({tag, "_rd"}, ifu_rdata_o | lsu_rdata_o, 32'd0);
   endtask

   // One arbitration round, entered and left at the negedge of an IDLE cycle.
   // delay = BUSY cycles before the bus acks; delay >= TIMEOUT means never.
   task automatic arb_cycle(input int delay, input logic [31:0] rd);
      int          win;
      logic [31:0] ea, ewd, erd;
      logic        ewe, eerr, done;
      logic [3:0]  ebe;
      int          i;
      chk("idle_req", {31'd0, mem_req_o}, 32'd0);
      chk("idle_ack", {30'd0, ifu_ack_o, lsu_ack_o}, 32'd0);
      if (ifu_req_i && lsu_req_i) win = (m_starve == STARVE_MAX) ? 1 : 2;
      else if (ifu_req_i)         win = 1;
      else if (lsu_req_i)         win = 2;
      else                        win = 0;
      obs_win = 0;
      if (win == 0) begin
         @(negedge clk_i);
         return;
      end
      if (win == 1) begin
         ea = ifu_addr_i; ewe = 1'b0; ebe = 4'hF; ewd = '0;
         m_starve = 0;
      end else begin
         ea = lsu_addr_i; ewe = lsu_we_i; ebe = lsu_be_i; ewd = lsu_wdata_i;
         if (ifu_req_i && m_starve < STARVE_MAX) m_starve++;
      end
      @(negedge clk_i);
      i = 0;
      done = 1'b0;
      while (!done) begin
         mem_ack_i   = (i == delay);
         mem_rdata_i = (i == delay) ? rd : $urandom;
         chk("busy_req", {31'd0, mem_req_o}, 32'd1);
         chk("busy_ack", {30'd0, ifu_ack_o, lsu_ack_o}, 32'd0);
         if (i == 0) begin
            chk("mem_addr", mem_addr_o, ea);
            chk("mem_we_be", {27'd0, mem_we_o, mem_be_o}, {27'd0, ewe, ebe});
            chk("mem_wdata", mem_wdata_o, ewd);
         end
         if (i == delay || i == TIMEOUT - 1) done = 1'b1;
         else begin
            i++;
            @(negedge clk_i);
         end
      end
      eerr = (delay >= TIMEOUT);
      erd  = eerr ? 32'd0 : rd;
      @(negedge clk_i);
      mem_ack_i   = 1'($urandom);
      mem_rdata_i = $urandom;
      obs_win = ifu_ack_o ? 1 : (lsu_ack_o ? 2 : 0);
      chk("resp_req", {31'd0, mem_req_o}, 32'd0);
      chk("ifu_ack", {31'd0, ifu_ack_o}, {31'd0, win == 1});
      chk("lsu_ack", {31'd0, lsu_ack_o}, {31'd0, win == 2});
      chk("ifu_rdata", ifu_rdata_o, (win == 1) ? erd : 32'd0);
      chk("lsu_rdata", lsu_rdata_o, (win == 2) ? erd : 32'd0);
      chk("ifu_err", {31'd0, ifu_err_o}, {31'd0, (win == 1) && eerr});
      chk("lsu_err", {31'd0, lsu_err_o}, {31'd0, (win == 2) && eerr});
      if (win == 1) ifu_req_i = 1'b0;
      else          lsu_req_i = 1'b0;
      @(negedge clk_i);
      chk("post_ack", {30'd0, ifu_ack_o, lsu_ack_o}, 32'd0);
      chk("post_rd", ifu_rdata_o | lsu_rdata_o, 32'd0);
   endtask

   task automatic lsu_load(input logic [31:0] a);
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_be_i = 4'hF;
      lsu_addr_i = a; lsu_wdata_i = $urandom;
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      chk_all_zero("reset");
      rst_n_i = 1'b1;
      @(negedge clk_i);

      // IFU only
      ifu_req_i = 1'b1; ifu_addr_i = 32'h100;
      arb_cycle(0, 32'h000CF5BD);

      // Simultaneous requests: LSU first, then IFU
      ifu_req_i = 1'b1; ifu_addr_i = 32'h200;
      lsu_load(32'h40);
      arb_cycle(0, $urandom);
      chk("simul_first", obs_win, 2);
      arb_cycle(1, $urandom);
      chk("simul_second", obs_win, 1);

      // Starvation guard with IFU held
      ifu_req_i = 1'b1; ifu_addr_i = 32'h300;
      seq = '0;
      for (int k = 0; k < 6; k++) begin
         lsu_load(32'h1000 + 32'(k * 4));
         arb_cycle(k % 3, $urandom);
         seq = {seq[4:0], obs_win == 1};
      end
      chk("starve_seq", {26'd0, seq}, {26'd0, 6'b000010});

      // Byte store
      lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'b0001;
      lsu_addr_i = 32'h3; lsu_wdata_i = 32'hAB;
      arb_cycle(2, $urandom);

      // Timeout followed by a normal load
      lsu_load(32'h44);
      arb_cycle(TIMEOUT + 5, $urandom);
      lsu_load(32'h48);
      arb_cycle(TIMEOUT - 1, 32'h5A5A1234);

      // Reset while BUSY
      lsu_load(32'h80);
      @(negedge clk_i);
      chk("rst_busy", {31'd0, mem_req_o}, 32'd1);
      rst_n_i = 1'b0; lsu_req_i = 1'b0; mem_ack_i = 1'b0;
      @(negedge clk_i);
      chk_all_zero("midrst");
      rst_n_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = $urandom;
      m_starve = 0;
      @(negedge clk_i);
      chk("late_ack", {29'd0, ifu_ack_o, lsu_ack_o, mem_req_o}, 32'd0);
      mem_ack_i = 1'b0;
      ifu_req_i = 1'b1; ifu_addr_i = 32'h400;
      arb_cycle(1, 32'hCAFEF00D);

      // Randomized traffic
      repeat (150) begin
         if (!ifu_req_i && $urandom_range(0, 2) != 0) begin
            ifu_req_i = 1'b1; ifu_addr_i = $urandom & 32'hFFFF_FFFC;
         end
         if (!lsu_req_i && $urandom_range(0, 3) != 0) begin
            lsu_req_i = 1'b1; lsu_we_i = 1'($urandom); lsu_be_i = 4'($urandom);
            lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
         end
         if (!lsu_req_i && !ifu_req_i) mem_ack_i = 1'($urandom);
         arb_cycle(($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 3)), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
